// File: rtl/dmac_ahb_pkg.sv
// dmac_ahb_pkg: shared AHB-Lite types and address map for the DMA peripheral slave
package dmac_ahb_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {HR_OKAY = 2'b00, HR_ERROR = 2'b01} hresp_t;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_ERR1, ST_ERR2} state_t;
  localparam logic [1:0] HSIZE_WORD = 2'b10;
  localparam logic [11:0] CFG_BASE = 12'h0A0;
  localparam logic [11:0] BUF_BASE = 12'h100;
  localparam logic [1:0] CFG_SADDR = 2'd0;
  localparam logic [1:0] CFG_DADDR = 2'd1;
  localparam logic [1:0] CFG_SIZE = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;
endpackage

// File: rtl/ahb_slave_buffer.sv
// ahb_slave_buffer: byte-strobed word array, asynchronous read, synchronous write
module ahb_slave_buffer #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [3:0]    i_strb,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we)
      for (int b = 0; b < 4; b++)
        if (i_strb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/ahb_peri_slave.sv
// ahb_peri_slave: AHB-Lite responder with read-only DMA config window, data buffer
// and a DMA request flop feeding the DMAC.
module ahb_peri_slave
  import dmac_ahb_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [1:0]  HSize,
  input  logic [3:0]  HBurst,
  input  logic [31:0] HWData,
  input  logic [3:0]  HWStrb,
  input  logic        HReady,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  output logic [31:0] HRData,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [31:0] cfg_wdata,
  input  logic        peri_start,
  input  logic        dma_done,
  output logic        dma_req
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [12:0] BUF_END = {1'b0, BUF_BASE} + 13'(4 * MEM_DEPTH);

  function automatic logic is_cfg(input logic [11:0] a);
    return a >= CFG_BASE && a < CFG_BASE + 12'h010;
  endfunction

  function automatic logic is_buf(input logic [11:0] a);
    return {1'b0, a} >= {1'b0, BUF_BASE} && {1'b0, a} < BUF_END;
  endfunction

  state_t      r_state, w_next;
  logic [11:0] r_addr;
  logic        r_write;
  logic [2:0]  r_wcnt;
  logic [31:0] r_cfg [4];
  logic        r_dma_req;
  logic        w_take, w_err, w_buf_we, w_rd_resp;
  logic [31:0] w_buf_rdata;
  logic        w_unused;

  assign w_unused = ^{HBurst, HAddr[31:12], HTrans[0]};
  assign w_take = HSel & HReady & HTrans[1] &
                  (r_state == ST_IDLE || r_state == ST_RESP || r_state == ST_ERR2);
  // Errors are decided from the live address phase so ERR1 starts on the next cycle.
  assign w_err = (HAddr[1:0] != 2'b00) || (HSize != HSIZE_WORD) ||
                 !(is_cfg(HAddr[11:0]) || is_buf(HAddr[11:0])) ||
                 (is_cfg(HAddr[11:0]) && HWrite);

  always_comb begin
    w_next = ST_IDLE;
    unique case (r_state)
      ST_WAIT: w_next = (r_wcnt == 3'(WAIT_STATES - 1)) ? ST_RESP : ST_WAIT;
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = !w_take ? ST_IDLE : w_err ? ST_ERR1 : (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt <= '0;
      r_addr <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wcnt <= (r_state == ST_WAIT && w_next == ST_WAIT) ? r_wcnt + 3'd1 : 3'd0;
      if (w_take) begin
        r_addr <= HAddr[11:0];
        r_write <= HWrite;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cfg[i] <= '0;
      r_dma_req <= 1'b0;
    end else begin
      if (cfg_we) r_cfg[cfg_idx] <= cfg_wdata;
      r_dma_req <= peri_start | (r_dma_req & ~dma_done);
    end

  assign w_buf_we = (r_state == ST_RESP) && r_write;
  assign w_rd_resp = (r_state == ST_RESP) && !r_write;

  ahb_slave_buffer #(.DEPTH(MEM_DEPTH), .AW(AW)) u_buf (
    .clk(clk),
    .i_we(w_buf_we),
    .i_idx(AW'((r_addr - BUF_BASE) >> 2)),
    .i_strb(HWStrb),
    .i_wdata(HWData),
    .o_rdata(w_buf_rdata)
  );

  assign HReadyOut = !(r_state == ST_WAIT || r_state == ST_ERR1);
  assign HResp = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HR_ERROR : HR_OKAY;
  assign HRData = !w_rd_resp ? 32'd0 : is_cfg(r_addr) ? r_cfg[r_addr[3:2]] : w_buf_rdata;
  assign dma_req = r_dma_req;
endmodule

// File: doc/ahb_peri_slave.md
# ahb_peri_slave

AHB-Lite responder modelling a DMA-capable peripheral; it is the slave the DMAC master reads and writes. It exposes a read-only 4-word channel-configuration window at offsets 0x0A0–0x0AC (source address, destination address, transfer size, control) and a word-addressed data buffer at 0x100. It supports programmable wait states, two-cycle ERROR responses and back-to-back pipelined transfers. It also raises the 1-bit DMA request line that feeds the DMAC request input.

## Interface
Parameters:
- MEM_DEPTH, 64: data buffer depth in 32-bit words, power of two, ≤ 64.
- WAIT_STATES, 0: HReadyOut-low cycles inserted in every OKAY data phase, 0–7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- HSel  in  1  slave select.
- HAddr  in  32  address; only [11:0] are decoded.
- HTrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWrite  in  1  1 = write.
- HSize  in  2  transfer size; only word (2'b10) is legal.
- HBurst  in  4  burst type; ignored, each beat is treated independently.
- HWData  in  32  write data, sampled in the data phase.
- HWStrb  in  4  byte write strobes, sampled in the data phase.
- HReady  in  1  bus-wide ready.
- HReadyOut  out  1  slave ready.
- HResp  out  2  response: 00 OKAY, 01 ERROR.
- HRData  out  32  read data.
- cfg_we  in  1  peripheral-side write to a config word.
- cfg_idx  in  2  config word index: 0 SAddr, 1 DAddr, 2 Size, 3 Ctrl.
- cfg_wdata  in  32  config write data.
- peri_start  in  1  pulse; sets dma_req.
- dma_done  in  1  pulse, driven from DMAC irq; clears dma_req.
- dma_req  out  1  level DMA request to the DMAC.

## Operation
- **Address phase accept:** HSel & HReady & HTrans[1]. On accept, register HAddr[11:0], HWrite, HSize.
- **IDLE/BUSY or unselected:** OKAY response, zero wait.
- **Decode of an accepted transfer:**
  - cfg window: 0x0A0 + 4·i → config word i, read-only.
  - buffer: 0x100 to 0x100 + 4·MEM_DEPTH − 4 → word (HAddr − 0x100) >> 2.
  - ERROR cases: any other address; HAddr[1:0] ≠ 0; HSize ≠ 2'b10; a write to the cfg window.
- **FSM states:** IDLE, WAIT, RESP, ERR1, ERR2.
  - IDLE → RESP on an accepted OKAY transfer when WAIT_STATES = 0; otherwise IDLE → WAIT.
  - WAIT: counter counts WAIT_STATES cycles with HReadyOut = 0, then moves to RESP.
  - RESP: HReadyOut = 1 and HResp = OKAY. Reads drive HRData. Writes commit the HWStrb-selected bytes of HWData at the clock edge.
  - A new transfer accepted in RESP goes directly to WAIT, RESP or ERR1 (pipelined). Otherwise RESP → IDLE.
  - Any accepted ERROR transfer goes to ERR1: HReadyOut = 0, HResp = 01.
  - ERR1 → ERR2: HReadyOut = 1, HResp = 01. ERR2 then behaves like RESP for accepting the next transfer.
  - Erroring writes modify nothing.
- **HRData:** drives 0 in every non-read-response cycle.
- **Config words:** written only via cfg_we/cfg_idx. If an AHB read of word i responds in the same cycle as cfg_we to word i, the read returns the old value.
- **dma_req:** set by peri_start, cleared by dma_done. If both pulse in the same cycle, set wins.

## Timing
- Reset values: HReadyOut = 1, HResp = 00, HRData = 0, dma_req = 0, all config words = 0, FSM = IDLE, wait counter = 0. Buffer contents are not reset.
- Read latency: data is valid in the cycle where HReadyOut = 1, which is WAIT_STATES + 1 cycles after the address phase.
- Read-after-write to the same word, issued back-to-back, returns the newly written data.
- HReady low from another slave while this slave is idle: no address is accepted.
- rst asserted mid-transfer: the FSM returns to IDLE immediately, no write commits, and the next cycle is OKAY/ready.
- ERROR response always takes exactly 2 cycles, independent of WAIT_STATES.

## Structure
- Shared package dmac_ahb_pkg holds:
  - htrans_t (IDLE/BUSY/NONSEQ/SEQ) and hresp_t (OKAY/ERROR) enums.
  - HSIZE_WORD.
  - CFG_BASE = 0x0A0 and BUF_BASE = 0x100.
  - Config index constants.
- Sub-module ahb_slave_buffer: byte-strobed MEM_DEPTH × 32 array with asynchronous read and synchronous write.
- Top level contains the decoder, FSM, wait counter, config registers and dma_req flop.

## Test plan
- Reset, then cfg_we idx 0–3 with 0x2000_0000, 0x3000_0000, 0x10, 0x0001_0024; DMAC-style reads of 0x0A0–0x0AC → the same four words, OKAY.
- WAIT_STATES = 2: write 0xDEADBEEF to 0x104 with HWStrb = 0011, then read 0x104 → 2 ready-low cycles per beat; data 0x0000BEEF (buffer pre-cleared).
- NONSEQ + 3×SEQ writes to 0x100–0x10C followed by back-to-back reads → each beat completes in 1 cycle (WAIT_STATES = 0), with the correct data per word.
- Write to 0x0A4, read 0x200, and HSize = 01 read of 0x100 → each gives ERROR over 2 cycles (ReadyOut 0 then 1); config and buffer are unchanged.
- peri_start → dma_req = 1 the next cycle; dma_done and peri_start in the same cycle → stays 1; dma_done alone → 0.
- Assert rst in the WAIT state of a write → HReadyOut = 1 and HResp = 00 immediately; the target word is unmodified.
